shift_reg_prog: RTL and testbench

- Parametrised successor to the team's fixed 16-bit x 17-stage pipeline delay register.
- Delays a data word and its valid tag by a run-time-selectable number of enabled clocks, from 1 to MAX_DEPTH.
- Adds clock-enable stall, synchronous flush, asynchronous reset and a priming indicator.
- Sits in the EDC datapath, balancing latency between a data path and its parallel check/syndrome path.

---
 rtl/shift_reg_prog.sv | 95 +++++++++
 tb/tb_shift_reg_prog.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_prog.sv
// Programmable-depth delay line for a data word plus valid tag (1..MAX_DEPTH enabled clocks).
// Latency: depth_eff enabled edges from the capture edge; the tap is read combinationally, no output register.
// Backpressure: none; en low freezes every stage and the fill count, flush clears valids and fill.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   en, flush         shift enable (hold when low), synchronous invalidate (wins over en)
//   d_in, d_valid     word and valid tag captured into stage 1 on an enabled edge
//   depth_sel         requested delay; 0 clamps to 1, > MAX_DEPTH clamps to MAX_DEPTH
//   d_out, q_valid    word and tag at the selected tap
//   primed            at least depth_eff enabled shifts since reset/flush
//   depth_err         depth_sel was clamped (combinational)
module shift_reg_prog #(
  parameter int WIDTH     = 16,
  parameter int MAX_DEPTH = 32,
  parameter int DEPTH_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               flush,
  input  logic [WIDTH-1:0]   d_in,
  input  logic               d_valid,
  input  logic [DEPTH_W-1:0] depth_sel,
  output logic [WIDTH-1:0]   d_out,
  output logic               q_valid,
  output logic               primed,
  output logic               depth_err
);

  localparam logic [DEPTH_W-1:0] MAX_SEL = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] ONE     = DEPTH_W'(1);

  // Index 0 is stage 1 (nearest the input).
  logic [WIDTH-1:0]   data_q [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] vld_q;
  logic [DEPTH_W-1:0] fill_q;
  logic [DEPTH_W-1:0] depth_eff;
  logic [DEPTH_W-1:0] tap;

  // Clamp the requested depth into 1..MAX_DEPTH and flag when clamping happened.
  always_comb begin
    depth_eff = depth_sel;
    depth_err = 1'b0;
    if (depth_sel == '0) begin
      depth_eff = ONE;
      depth_err = 1'b1;
    end else if (depth_sel > MAX_SEL) begin
      depth_eff = MAX_SEL;
      depth_err = 1'b1;
    end
  end

  assign tap = depth_eff - ONE;

  // Tap mux written as a compare loop so the select width need not match the array index width.
  always_comb begin
    d_out   = '0;
    q_valid = 1'b0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (tap == DEPTH_W'(i)) begin
        d_out   = data_q[i];
        q_valid = vld_q[i];
      end
    end
  end

  // primed follows the live depth_eff, so a depth change re-evaluates it at once.
  assign primed = (fill_q >= depth_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_DEPTH; k++) begin
        data_q[k] <= '0;
      end
      vld_q  <= '0;
      fill_q <= '0;
    end else if (flush) begin
      // Data is left in place; only the tags and fill count are cleared.
      vld_q  <= '0;
      fill_q <= '0;
    end else if (en) begin
      data_q[0] <= d_in;
      vld_q[0]  <= d_valid;
      for (int k = 1; k < MAX_DEPTH; k++) begin
        data_q[k] <= data_q[k-1];
        vld_q[k]  <= vld_q[k-1];
      end
      if (fill_q != MAX_SEL) begin
        fill_q <= fill_q + ONE;
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_prog.sv
module tb_shift_reg_prog;

  localparam int WIDTH = 16;
  localparam int MAXD  = 32;
  localparam int DW    = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            flush;
  logic [WIDTH-1:0] d_in;
  logic            d_valid;
  logic [DW-1:0]   depth_sel;
  logic [WIDTH-1:0] d_out;
  logic            q_valid;
  logic            primed;
  logic            depth_err;

  int vectors    = 0;
  int miscompares = 0;

  shift_reg_prog #(.WIDTH(WIDTH), .MAX_DEPTH(MAXD), .DEPTH_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .d_in(d_in),
    .d_valid(d_valid), .depth_sel(depth_sel), .d_out(d_out),
    .q_valid(q_valid), .primed(primed), .depth_err(depth_err)
  );

  always #5 clk = ~clk;

  // Reference model: history of captured {valid,data} words, newest first,
  // plus a count of enabled shifts since reset/flush.
  logic [16:0] hist[$];
  int          fill_cnt;

  function automatic int eff_depth(input int ds);
    if (ds == 0) return 1;
    if (ds > MAXD) return MAXD;
    return ds;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < MAXD; i++) hist.push_back(17'h0);
    fill_cnt = 0;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    int de;
    de = eff_depth(int'(depth_sel));
    cmp({tag, ".d_out"},   32'(d_out),     32'(hist[de-1][15:0]));
    cmp({tag, ".q_valid"}, 32'(q_valid),   32'(hist[de-1][16]));
    cmp({tag, ".primed"},  32'(primed),    32'(fill_cnt >= de));
    cmp({tag, ".err"},     32'(depth_err), 32'(int'(depth_sel) == 0 || int'(depth_sel) > MAXD));
  endtask

  // Drive inputs, take one clock edge, advance the model, settle 1ns past the edge.
  task automatic step(input logic e, input logic f, input logic v,
                      input logic [15:0] d, input logic [DW-1:0] ds);
    en = e; flush = f; d_valid = v; d_in = d; depth_sel = ds;
    @(posedge clk);
    if (f) begin
      for (int i = 0; i < MAXD; i++) hist[i][16] = 1'b0;
      fill_cnt = 0;
    end else if (e) begin
      hist.push_front({v, d});
      void'(hist.pop_back());
      if (fill_cnt < MAXD) fill_cnt++;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [15:0] exp_d;
    logic        exp_v;
    logic        exp_p;
  } vec_t;

  vec_t tbl[8];
  logic [15:0] got_q[$];
  logic [15:0] frozen;

  initial begin
    // Alternating pattern at depth 3: word from edge j is visible after edge j+2.
    tbl[0] = '{1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};

    rst_n = 1'b0; en = 1'b0; flush = 1'b0; d_in = '0; d_valid = 1'b0;
    depth_sel = 6'd17;
    model_reset();
    #12;
    chk_model("por");
    depth_sel = 6'd0;
    #1;
    cmp("por.err_sel0", 32'(depth_err), 32'd1);
    depth_sel = 6'd17;
    @(negedge clk);
    rst_n = 1'b1;

    // Legacy 17-stage behaviour.
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b0, 1'b1, 16'(i), 6'd17);
      chk_model("d17");
      if (i == 16) begin
        cmp("d17.q_at16", 32'(q_valid), 32'd0);
        cmp("d17.p_at16", 32'(primed), 32'd0);
      end
      if (i == 17) begin
        cmp("d17.d_at17", 32'(d_out), 32'd1);
        cmp("d17.p_at17", 32'(primed), 32'd1);
      end
      if (i == 30) cmp("d17.d_at30", 32'(d_out), 32'd14);
    end

    // Table: alternating valid/data at depth 3.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, tbl[i].v, tbl[i].d, 6'd3);
      cmp($sformatf("alt[%0d].d", i), 32'(d_out),   32'(tbl[i].exp_d));
      cmp($sformatf("alt[%0d].v", i), 32'(q_valid), 32'(tbl[i].exp_v));
      cmp($sformatf("alt[%0d].p", i), 32'(primed),  32'(tbl[i].exp_p));
    end

    // Stall at depth 4: no word lost or duplicated, output frozen while en is low.
    do_reset();
    got_q.delete();
    for (int i = 0; i < 14; i++) begin
      logic e;
      logic [15:0] w;
      e = !(i >= 2 && i <= 4);
      w = 16'hA001 + 16'(i < 2 ? i : i - 3);
      if (i == 2) frozen = d_out;
      step(e, 1'b0, e && w <= 16'hA008, w, 6'd4);
      chk_model("stall");
      if (!e) cmp("stall.frozen", 32'(d_out), 32'(frozen));
      if (e && q_valid) got_q.push_back(d_out);
      if (i == 6) cmp("stall.first", 32'(d_out), 32'hA001);
    end
    cmp("stall.count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < got_q.size() && i < 8; i++)
      cmp($sformatf("stall.seq[%0d]", i), 32'(got_q[i]), 32'hA001 + 32'(i));

    // Clamped depths.
    step(1'b1, 1'b0, 1'b1, 16'h1234, 6'd0);
    chk_model("sel0");
    cmp("sel0.d", 32'(d_out), 32'h1234);
    cmp("sel0.err", 32'(depth_err), 32'd1);
    for (int i = 0; i < 70; i++) begin
      step(1'b1, 1'b0, 1'b1, 16'(16'h5000 + i), 6'd40);
      chk_model("sel40");
      if (i == 40) cmp("sel40.d", 32'(d_out), 32'h5000 + 32'd9);
    end

    // Flush at depth 8.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      step(1'b1, i == 15, 1'b1, 16'(16'hB000 + i), 6'd8);
      chk_model("flush");
      if (i >= 15 && i <= 22) cmp("flush.qv_low", 32'(q_valid), 32'd0);
      if (i == 23) begin
        cmp("flush.first_d", 32'(d_out), 32'hB000 + 32'd16);
        cmp("flush.first_v", 32'(q_valid), 32'd1);
        cmp("flush.primed", 32'(primed), 32'd1);
      end
    end

    // Asynchronous reset between edges at depth 5.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, 16'(16'hC000 + i), 6'd5);
      chk_model("arst.pre");
    end
    #2 rst_n = 1'b0;
    #1;
    cmp("arst.d", 32'(d_out), 32'd0);
    cmp("arst.v", 32'(q_valid), 32'd0);
    cmp("arst.p", 32'(primed), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, 16'(16'hD000 + i), 6'd5);
      chk_model("arst.post");
      if (i == 4) cmp("arst.lat5", 32'(d_out), 32'hD000);
    end

    // Randomized traffic against the model.
    begin
      logic [DW-1:0] ds;
      ds = 6'd7;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 19) == 0) ds = DW'($urandom_range(0, 40));
        step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
             1'($urandom), 16'($urandom), ds);
        chk_model("rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
